// File: rtl/regfile_np.sv
// -----------------------------------------------------------------------------
// regfile_np
//
// Parametrised multi-port register file. It has NREAD registered read ports and
// NWRITE write ports over a DEPTH x WIDTH array. When two or more enabled write
// ports target the same address, the lowest-numbered port wins. A sticky
// collision flag records each such event.
//
// Optional feature (compile-time macro):
//   REGFILE_NP_BYPASS_EN - a non-stalled read that samples an address being
//                          written at the same edge returns the winning wdata
//                          instead of the old array contents.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       asynchronous, active-high reset (array, rdata and coll to zero)
//   raddr     NREAD*AW read addresses, port i at [i*AW +: AW]
//   rdata     NREAD*WIDTH registered read data, port i at [i*WIDTH +: WIDTH]
//   stall     holds rdata; raddr is not sampled while high
//   wen       NWRITE per-port write enables
//   waddr     NWRITE*AW write addresses
//   wdata     NWRITE*WIDTH write data
//   coll      sticky write-collision flag
//   coll_clr  synchronous clear of coll; a new collision in the same cycle wins
//   probe     combinational view of array[PROBE_IDX]
// -----------------------------------------------------------------------------
module regfile_np #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int NREAD     = 2,
    parameter int NWRITE    = 2,
    parameter int ZERO_REG  = 1,
    parameter int PROBE_IDX = 3,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     raddr,
    output logic [NREAD*WIDTH-1:0]  rdata,
    input  logic                    stall,
    input  logic [NWRITE-1:0]       wen,
    input  logic [NWRITE*AW-1:0]    waddr,
    input  logic [NWRITE*WIDTH-1:0] wdata,
    output logic                    coll,
    input  logic                    coll_clr,
    output logic [WIDTH-1:0]        probe
);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [NWRITE-1:0]      wr_ok_p0;
    logic                   coll_hit_p0;
    logic [WIDTH-1:0]       rd_val_p0 [NREAD];
    logic [NREAD*WIDTH-1:0] rdata_p1;
    logic                   coll_p1;

    // An address is backed by storage if it is in range and is not the
    // hard-wired zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // ---- stage p0: write arbitration, collision detect, read selection ----
    // A port keeps its write only if no lower-numbered enabled port targets the
    // same raw address. The collision check uses raw addresses, so address 0
    // and out-of-range addresses also count.
    always_comb begin
        wr_ok_p0    = '0;
        coll_hit_p0 = 1'b0;
        for (int k = 0; k < NWRITE; k++) begin
            wr_ok_p0[k] = wen[k] && addr_live(waddr[k*AW +: AW]);
            for (int j = 0; j < k; j++) begin
                if (wen[j] && wen[k] && (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
                    wr_ok_p0[k] = 1'b0;
                    coll_hit_p0 = 1'b1;
                end
            end
        end
    end

    // Winners are unique per address, so at most one port can match a
    // forwarded read.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_val_p0[i] = '0;
            if (addr_live(raddr[i*AW +: AW])) begin
                rd_val_p0[i] = mem[raddr[i*AW +: AW]];
`ifdef REGFILE_NP_BYPASS_EN
                for (int k = 0; k < NWRITE; k++) begin
                    if (wr_ok_p0[k] && (waddr[k*AW +: AW] == raddr[i*AW +: AW]))
                        rd_val_p0[i] = wdata[k*WIDTH +: WIDTH];
                end
`endif
            end
        end
    end

    // ---- stage p1: array update, registered read data, sticky flag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++)
                mem[a] <= '0;
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_ok_p0[k])
                    mem[waddr[k*AW +: AW]] <= wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_p1 <= '0;
        end else if (!stall) begin
            for (int i = 0; i < NREAD; i++)
                rdata_p1[i*WIDTH +: WIDTH] <= rd_val_p0[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            coll_p1 <= 1'b0;
        else if (coll_hit_p0)
            coll_p1 <= 1'b1;
        else if (coll_clr)
            coll_p1 <= 1'b0;
    end

    assign rdata = rdata_p1;
    assign coll  = coll_p1;

    generate
        if ((ZERO_REG != 0) && (PROBE_IDX == 0)) begin : g_probe_zero
            assign probe = '0;
        end else begin : g_probe_reg
            assign probe = mem[PROBE_IDX];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_np.sv
// -----------------------------------------------------------------------------
// tb_regfile_np
//
// Self-checking bench for regfile_np with DEPTH=24, NREAD=4, NWRITE=3. A
// behavioural model derives the expected rdata, coll and probe values from the
// register-file rules. A compare process checks the DUT against the model on
// every falling edge. Directed scenarios pin hand-computed literals, and a
// randomized phase follows. The bench follows REGFILE_NP_BYPASS_EN when it is
// defined.
// -----------------------------------------------------------------------------
module tb_regfile_np;

    localparam int W  = 32;
    localparam int D  = 24;
    localparam int NR = 4;
    localparam int NW = 3;
    localparam int AW = 5;
`ifdef REGFILE_NP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR*AW-1:0]  raddr = '0;
    logic [NR*W-1:0]   rdata;
    logic              stall = 1'b0;
    logic [NW-1:0]     wen = '0;
    logic [NW*AW-1:0]  waddr = '0;
    logic [NW*W-1:0]   wdata = '0;
    logic              coll;
    logic              coll_clr = 1'b0;
    logic [W-1:0]      probe;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_np #(
        .WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .PROBE_IDX(3)
    ) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .stall(stall),
        .wen(wen), .waddr(waddr), .wdata(wdata), .coll(coll),
        .coll_clr(coll_clr), .probe(probe)
    );

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_rd  [NR];
    logic         m_coll;
    bit           m_claim [32];
    logic [W-1:0] m_win   [32];
    bit           m_hit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < D; a++) m_mem[a] = '0;
            for (int i = 0; i < NR; i++) m_rd[i] = '0;
            m_coll = 1'b0;
        end else begin
            // The first enabled port to claim an address owns it; any later
            // claim is a collision.
            for (int a = 0; a < 32; a++) m_claim[a] = 1'b0;
            m_hit = 1'b0;
            for (int j = 0; j < NW; j++) begin
                if (wen[j]) begin
                    int a;
                    a = int'(waddr[j*AW +: AW]);
                    if (m_claim[a]) m_hit = 1'b1;
                    else begin
                        m_claim[a] = 1'b1;
                        m_win[a]   = wdata[j*W +: W];
                    end
                end
            end
            if (!stall) begin
                for (int i = 0; i < NR; i++) begin
                    int a;
                    a = int'(raddr[i*AW +: AW]);
                    if (a == 0 || a >= D)          m_rd[i] = '0;
                    else if (BYP && m_claim[a])    m_rd[i] = m_win[a];
                    else                           m_rd[i] = m_mem[a];
                end
            end
            for (int a = 1; a < D; a++)
                if (m_claim[a]) m_mem[a] = m_win[a];
            if (m_hit)         m_coll = 1'b1;
            else if (coll_clr) m_coll = 1'b0;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NR; i++)
                check($sformatf("model_rdata%0d", i), rdata[i*W +: W], m_rd[i]);
            check("model_coll", {31'b0, coll}, {31'b0, m_coll});
            check("model_probe", probe, m_mem[3]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wen = '0; stall = 1'b0; coll_clr = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        wen[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*W +: W] = d;
    endtask

    task automatic rd(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rport(input int p);
        return rdata[p*W +: W];
    endfunction

    initial begin
        // initial reset
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // zero register
        idle(); wr(0, 5, 32'hDEADBEEF); wr(1, 3, 32'h33); tick();
        idle(); for (int i = 0; i < NR; i++) rd(i, 3); wr(1, 0, 32'h1234); tick();
        for (int i = 0; i < NR; i++) check("r3_all_ports", rport(i), 32'h33);
        idle(); for (int i = 0; i < NR; i++) rd(i, 0); tick();
        for (int i = 0; i < NR; i++) check("r0_reads_zero", rport(i), 32'h0);

        // asynchronous reset between edges
        idle(); rd(0, 5); tick();
        check("r5_before_rst", rport(0), 32'hDEADBEEF);
        check("probe_before_rst", probe, 32'h33);
        #2 rst = 1'b1;
        #1;
        check("rst_rdata0", rport(0), 32'h0);
        check("rst_probe", probe, 32'h0);
        check("rst_coll", {31'b0, coll}, 32'h0);
        #1 rst = 1'b0;
        rd(0, 5); tick();
        check("r5_after_rst", rport(0), 32'h0);

        // priority and collision
        idle(); wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h5555); tick();
        check("coll_set", {31'b0, coll}, 32'h1);
        idle(); rd(0, 7); tick();
        check("r7_port0_wins", rport(0), 32'hAAAA0000);
        check("coll_sticky", {31'b0, coll}, 32'h1);
        idle(); coll_clr = 1'b1; tick();
        check("coll_cleared", {31'b0, coll}, 32'h0);
        idle(); coll_clr = 1'b1; wr(1, 30, 32'hBAD); wr(2, 30, 32'hBAD2); tick();
        check("coll_set_beats_clr", {31'b0, coll}, 32'h1);
        idle(); rd(0, 30); rd(1, 7); tick();
        check("r30_out_of_range", rport(0), 32'h0);
        check("r7_intact", rport(1), 32'hAAAA0000);

        // stall
        idle(); wr(0, 4, 32'h11); tick();
        idle(); rd(0, 4); tick();
        check("stall_pre", rport(0), 32'h11);
        idle(); stall = 1'b1; wr(0, 4, 32'h22); rd(0, 9); tick();
        check("stall_hold", rport(0), 32'h11);
        idle(); rd(0, 4); tick();
        check("stall_release", rport(0), 32'h22);

        // read during write
        idle(); wr(0, 3, 32'hCAFE); rd(0, 3); tick();
        check("rdw_rdata", rport(0), BYP ? 32'hCAFE : 32'h0);
        check("rdw_probe", probe, 32'hCAFE);

        // four distinct reads in one cycle
        idle(); wr(0, 10, 32'hA0); wr(1, 11, 32'hB1); wr(2, 12, 32'hC2); tick();
        idle(); wr(0, 13, 32'hD3); tick();
        idle(); rd(0, 10); rd(1, 11); rd(2, 12); rd(3, 13); tick();
        check("quad_rd0", rport(0), 32'hA0);
        check("quad_rd1", rport(1), 32'hB1);
        check("quad_rd2", rport(2), 32'hC2);
        check("quad_rd3", rport(3), 32'hD3);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            idle();
            wen = NW'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) begin
                case ($urandom_range(0, 3))
                    0:       waddr[p*AW +: AW] = AW'($urandom_range(24, 31));
                    1:       waddr[p*AW +: AW] = AW'($urandom_range(0, 23));
                    default: waddr[p*AW +: AW] = AW'($urandom_range(0, 5));
                endcase
                wdata[p*W +: W] = $urandom;
            end
            for (int i = 0; i < NR; i++)
                raddr[i*AW +: AW] = AW'(($urandom_range(0, 1) == 0) ?
                                        $urandom_range(0, 31) : $urandom_range(0, 5));
            stall    = ($urandom_range(0, 4) == 0);
            coll_clr = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-port general-purpose register file, successor to the fixed 2-read/2-write core register file. It provides NREAD registered read ports and NWRITE write ports over a DEPTH x WIDTH array, and gives the lowest-numbered write port priority on address conflicts. It adds an asynchronous reset, a sticky write-collision status and a probe port. The block sits between decode (read ports) and writeback (write ports) of the pipeline.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers; AW = $clog2(DEPTH).
- NREAD, 2: number of read ports, 1..4.
- NWRITE, 2: number of write ports, 1..4; port 0 has highest priority.
- ZERO_REG, 1: when 1, register 0 reads as zero and writes to it are discarded.
- PROBE_IDX, 3: register index exposed on `probe` (return-value register for test).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NREAD*AW  read addresses; port i at [i*AW +: AW].
- rdata  out  NREAD*WIDTH  registered read data; port i at [i*WIDTH +: WIDTH].
- stall  in  1  when high, rdata holds and raddr is not sampled.
- wen  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*AW  write addresses.
- wdata  in  NWRITE*WIDTH  write data.
- coll  out  1  sticky flag: two or more enabled write ports hit the same address in one cycle.
- coll_clr  in  1  synchronous clear of coll.
- probe  out  WIDTH  combinational view of array[PROBE_IDX].

## Operation
- Reset (rst=1, asynchronous): every array entry = 0, every rdata port = 0, coll = 0. Writes and reads are suppressed while rst is high.
- Write resolution per address: the lowest-index enabled port targeting that address wins. Higher-index ports to the same address are dropped.
- Writes occur regardless of stall.
- Writes with waddr >= DEPTH are ignored.
- If ZERO_REG=1, writes to address 0 are ignored.
- Read, when !stall at an edge: rdata[i] <= value for raddr[i].
  - The value is 0 if (ZERO_REG && raddr==0) or raddr >= DEPTH.
  - Otherwise it is the array entry, subject to the bypass rules in Configuration.
- Read, when stall=1: rdata unchanged, even if the addressed register is written that cycle.
- Collision detection: any pair j<k with wen[j] && wen[k] && waddr[j]==waddr[k] sets coll at that edge.
  - This includes address 0 and out-of-range addresses.
  - coll_clr=1 clears coll. If a new collision and coll_clr occur in the same cycle, set wins (coll=1).
- probe: continuously reflects array[PROBE_IDX] and updates one edge after a write.
  - If ZERO_REG=1 and PROBE_IDX=0, probe reads 0.

## Timing
- Read latency: 1 cycle. raddr sampled at edge N gives rdata valid after edge N.
- Write latency: a write presented before edge N is in the array after edge N.
- Read-during-write to the same address at edge N:
  - Without the bypass macro: rdata gets the old value.
  - With the bypass macro: rdata gets the winning write data.
- rst deasserting mid-stream: the first edge with rst low behaves as a normal cycle.
- coll updates one edge after the colliding cycle and stays high until cleared.

## Configuration
- REGFILE_NP_BYPASS_EN defined:
  - A read sampled at an edge where an enabled write (winning port after priority) targets the same valid, non-zero-reg address returns that wdata instead of the array value.
  - Applies per read port independently.
  - Does not affect stalled reads.
- Not defined: no forwarding; the read returns the pre-edge array contents (legacy behaviour).

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst asynchronously between edges -> rdata, probe and coll go to 0 immediately; reading r5 afterwards returns 0.
- Zero register: write 0x1234 to r0 via port 1, then read r0 on both ports -> rdata = 0 on both ports.
- Priority/collision: port0 writes 0xAAAA0000 to r7 while port1 writes 0x5555 to r7 -> read r7 = 0xAAAA0000 and coll = 1 next cycle. Assert coll_clr alone -> coll = 0. Assert coll_clr together with a new collision -> coll stays 1.
- Stall: read r4 = 0x11 to get rdata = 0x11. Raise stall, write r4 = 0x22 and change raddr to r9 -> rdata stays 0x11. Drop stall -> rdata = 0x22 (r4 re-read) or r9's value, per raddr.
- Read-during-write: write r3 = 0xCAFE and read r3 at the same edge.
  - Bypass off: rdata = old value 0. Bypass on: rdata = 0xCAFE.
  - In both builds, probe (PROBE_IDX=3) = 0xCAFE after the edge.
- Parameters: DEPTH=24, NREAD=4, NWRITE=3. Write address 30 -> ignored, and a read of 30 returns 0. All four read ports read distinct registers correctly in the same cycle.
